// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: default pixel width, the pixel
// type, and the number of buffered rows required before a 3-row column is
// valid. The window stage imports the same package.
package sobel_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] pixel_t;

    // Rows that must already be buffered before the current row completes a
    // genuine 3-row column.
    localparam logic [1:0] ROWS_FOR_VALID = 2'd2;

    // Row counter advance that sticks at ROWS_FOR_VALID once enough rows exist.
    function automatic logic [1:0] row_sat_inc(input logic [1:0] row);
        if (row >= ROWS_FOR_VALID) begin
            return ROWS_FOR_VALID;
        end
        return row + 2'd1;
    endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// Single-port line RAM, one image line deep. Reads are synchronous and
// read-before-write: when the same address is written on an edge, rdata
// returns the value stored before that write. Only the read register is
// reset; the storage array is never cleared.
module sobel_line_ram #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read of the pre-write contents; holds while the port is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sobel_line_buffer.sv
// Sobel line buffer: turns a raster stream of one pixel per clock into three
// vertically aligned pixels (rows y-2, y-1, y) per clock, with done_o flagging
// columns where all three rows are real image data.
//
// The two lines are held in a ping-pong pair of line RAMs. The current row is
// written into the bank chosen by the row parity; the read-before-write old
// value of that same bank is row y-2, and the other bank at the same column
// holds row y-1. This gives the same outputs as shifting line1 into line0,
// while every RAM stays a plain single-port synchronous memory.
//
// Optional feature macro: SOBEL_LINE_BUF_SOF_EN adds sof_i, which restarts
// the column/row position at column 0 of line 0 for the accompanying pixel.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = sobel_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              valid_i,
`ifdef SOBEL_LINE_BUF_SOF_EN
    input  logic              sof_i,
`endif
    output logic [DATA_W-1:0] d0_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic              done_o
);

    localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);

    logic [ADDR_W-1:0] col_cnt;
    logic [ADDR_W-1:0] col_eff;
    logic [1:0]        row_cnt;
    logic [1:0]        row_eff;
    logic              bank_cnt;
    logic              bank_eff;
    logic              bank_q;
    logic              take_pixel;
    logic              sof_take;
    logic [DATA_W-1:0] bank0_rdata;
    logic [DATA_W-1:0] bank1_rdata;

    assign take_pixel = valid_i && !rst;

`ifdef SOBEL_LINE_BUF_SOF_EN
    assign sof_take = valid_i && sof_i;
`else
    assign sof_take = 1'b0;
`endif

    // Position used by the current pixel: a start of frame forces column 0,
    // line 0 and bank 0 before that pixel is processed.
    always_comb begin
        col_eff  = col_cnt;
        row_eff  = row_cnt;
        bank_eff = bank_cnt;
        if (sof_take) begin
            col_eff  = '0;
            row_eff  = 2'd0;
            bank_eff = 1'b0;
        end
    end

    sobel_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) line0 (
        .clk   (clk),
        .rst   (rst),
        .en    (take_pixel),
        .we    (take_pixel && !bank_eff),
        .addr  (col_eff),
        .wdata (pixel_i),
        .rdata (bank0_rdata)
    );

    sobel_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) line1 (
        .clk   (clk),
        .rst   (rst),
        .en    (take_pixel),
        .we    (take_pixel && bank_eff),
        .addr  (col_eff),
        .wdata (pixel_i),
        .rdata (bank1_rdata)
    );

    // The bank written by the last accepted pixel supplies the oldest row.
    assign d0_o = bank_q ? bank1_rdata : bank0_rdata;
    assign d1_o = bank_q ? bank0_rdata : bank1_rdata;

    // Raster position, bank parity, newest-row register and done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt  <= '0;
            row_cnt  <= 2'd0;
            bank_cnt <= 1'b0;
            bank_q   <= 1'b0;
            d2_o     <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= valid_i && (row_eff == ROWS_FOR_VALID);
            if (valid_i) begin
                d2_o   <= pixel_i;
                bank_q <= bank_eff;
                if (col_eff == LAST_COL) begin
                    col_cnt  <= '0;
                    row_cnt  <= row_sat_inc(row_eff);
                    bank_cnt <= ~bank_eff;
                end else begin
                    col_cnt  <= col_eff + 1'b1;
                    row_cnt  <= row_eff;
                    bank_cnt <= bank_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Self-checking bench for sobel_line_buffer. A narrow instance (4 pixels per
// line) is exercised with directed and random streams against a reference
// model that keeps the accepted-pixel history; a full-width instance (640)
// checks line wrap over three complete lines.
// Optional feature macro: SOBEL_LINE_BUF_SOF_EN enables the start-of-frame cases.
module tb_sobel_line_buffer;

    localparam int W  = 4;
    localparam int WL = 640;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pixel = 8'h00;
    logic       valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] d0, d1, d2;
    logic       done;

    logic       w_rst = 1'b0;
    logic [7:0] w_pixel = 8'h00;
    logic       w_valid = 1'b0;
    logic       w_sof = 1'b0;
    logic [7:0] w_d0, w_d1, w_d2;
    logic       w_done;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [7:0] hist[$];
    logic [7:0] exp_d0 = 8'h00;
    logic [7:0] exp_d1 = 8'h00;
    logic [7:0] exp_d2 = 8'h00;
    logic       exp_done = 1'b0;
    logic       rows_known = 1'b1;

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    sobel_line_buffer #(.IMG_WIDTH(W), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .pixel_i (pixel),
        .valid_i (valid),
`ifdef SOBEL_LINE_BUF_SOF_EN
        .sof_i   (sof),
`endif
        .d0_o    (d0),
        .d1_o    (d1),
        .d2_o    (d2),
        .done_o  (done)
    );

    sobel_line_buffer #(.IMG_WIDTH(WL), .DATA_W(8)) dut_wide (
        .clk     (clk),
        .rst     (w_rst),
        .pixel_i (w_pixel),
        .valid_i (w_valid),
`ifdef SOBEL_LINE_BUF_SOF_EN
        .sof_i   (w_sof),
`endif
        .d0_o    (w_d0),
        .d1_o    (w_d1),
        .d2_o    (w_d2),
        .done_o  (w_done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle on the narrow instance, advance the reference model and
    // compare. The model views the stream as a history of accepted pixels
    // since the last reset or start of frame: pixel n sits on line n/W, and
    // its column partners are pixels n-W and n-2W.
    task automatic applyStimulus(input string tag, input logic [7:0] pix,
                                 input logic vld, input logic sf, input logic rs);
        int  n;
        logic sf_eff;
`ifdef SOBEL_LINE_BUF_SOF_EN
        sf_eff = sf;
`else
        sf_eff = 1'b0;
`endif
        rst   = rs;
        pixel = pix;
        valid = vld;
        sof   = sf_eff;
        @(posedge clk);
        #1;
        if (rs) begin
            hist.delete();
            exp_d0 = 8'h00;
            exp_d1 = 8'h00;
            exp_d2 = 8'h00;
            exp_done = 1'b0;
            rows_known = 1'b1;
        end else if (vld) begin
            if (sf_eff) hist.delete();
            n = hist.size();
            hist.push_back(pix);
            exp_d2 = pix;
            exp_done = (n >= 2 * W);
            if (exp_done) begin
                exp_d0 = hist[n - 2 * W];
                exp_d1 = hist[n - W];
                rows_known = 1'b1;
            end else begin
                rows_known = 1'b0;
            end
        end else begin
            exp_done = 1'b0;
        end
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        checkOutput({tag, "_d2"}, {24'd0, d2}, {24'd0, exp_d2});
        if (rows_known) begin
            checkOutput({tag, "_d0"}, {24'd0, d0}, {24'd0, exp_d0});
            checkOutput({tag, "_d1"}, {24'd0, d1}, {24'd0, exp_d1});
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int idx;
        logic [7:0] base;

        $display("[TB] reset check");
        applyStimulus("rst0", 8'hFF, 1'b1, 1'b0, 1'b1);
        applyStimulus("rst1", 8'hFF, 1'b1, 1'b0, 1'b1);
        checkOutput("rst_d0_zero", {24'd0, d0}, 32'd0);

        $display("[TB] fill and align");
        for (int p = 1; p <= 16; p++) begin
            applyStimulus("fill", 8'(p), 1'b1, 1'b0, 1'b0);
            if (p == 9) begin
                checkOutput("fill_p9_done", {31'd0, done}, 32'd1);
                checkOutput("fill_p9_d0", {24'd0, d0}, 32'd1);
                checkOutput("fill_p9_d1", {24'd0, d1}, 32'd5);
                checkOutput("fill_p9_d2", {24'd0, d2}, 32'd9);
            end
            if (p == 16) begin
                checkOutput("fill_p16_d0", {24'd0, d0}, 32'd8);
                checkOutput("fill_p16_d1", {24'd0, d1}, 32'd12);
                checkOutput("fill_p16_d2", {24'd0, d2}, 32'd16);
            end
        end

        $display("[TB] bubbles");
        applyStimulus("brst", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int p = 1; p <= 16; p++) begin
            applyStimulus("bub", 8'(p), 1'b1, 1'b0, 1'b0);
            if (p == 3 || p == 6 || p == 10) begin
                applyStimulus("bub_idle", 8'hAA, 1'b0, 1'b0, 1'b0);
                if (p == 10) begin
                    checkOutput("bub_hold_d0", {24'd0, d0}, 32'd2);
                    checkOutput("bub_hold_d1", {24'd0, d1}, 32'd6);
                end
            end
        end

        $display("[TB] reset mid-stream");
        applyStimulus("mrst", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int p = 1; p <= 11; p++) applyStimulus("mpre", 8'(p), 1'b1, 1'b0, 1'b0);
        applyStimulus("mpulse", 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("mpulse_done", {31'd0, done}, 32'd0);
        for (int p = 101; p <= 112; p++) begin
            applyStimulus("mpost", 8'(p), 1'b1, 1'b0, 1'b0);
            if (p == 108) checkOutput("mpost_p108_done", {31'd0, done}, 32'd0);
            if (p == 109) begin
                checkOutput("mpost_p109_done", {31'd0, done}, 32'd1);
                checkOutput("mpost_p109_d0", {24'd0, d0}, 32'd101);
                checkOutput("mpost_p109_d1", {24'd0, d1}, 32'd105);
            end
        end

`ifdef SOBEL_LINE_BUF_SOF_EN
        $display("[TB] start of frame");
        applyStimulus("srst", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int p = 1; p <= 12; p++) applyStimulus("spre", 8'(p), 1'b1, 1'b0, 1'b0);
        applyStimulus("ssof", 8'd50, 1'b1, 1'b1, 1'b0);
        checkOutput("ssof_done", {31'd0, done}, 32'd0);
        for (int p = 51; p <= 61; p++) begin
            applyStimulus("spost", 8'(p), 1'b1, 1'b0, 1'b0);
            if (p == 57) checkOutput("spost_p57_done", {31'd0, done}, 32'd0);
            if (p == 58) begin
                checkOutput("spost_p58_d0", {24'd0, d0}, 32'd50);
                checkOutput("spost_p58_d1", {24'd0, d1}, 32'd54);
                checkOutput("spost_p58_d2", {24'd0, d2}, 32'd58);
            end
        end
`endif

        $display("[TB] random stream");
        applyStimulus("rrst", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            applyStimulus("rnd", 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 149) == 0));
        end
        valid = 1'b0;
        rst   = 1'b0;
        sof   = 1'b0;

        $display("[TB] full-width wrap");
        w_rst = 1'b1;
        w_valid = 1'b1;
        w_pixel = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("wide_rst_done", {31'd0, w_done}, 32'd0);
        checkOutput("wide_rst_d2", {24'd0, w_d2}, 32'd0);
        w_rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3 * WL + 1; i++) begin
            w_valid = (i < 3 * WL);
            w_pixel = 8'(i % 256);
            @(posedge clk);
            #1;
            if (w_done) begin
                pulses++;
                idx  = i - 2 * WL;
                base = 8'(idx % 256);
                checkOutput("wide_d0", {24'd0, w_d0}, {24'd0, base});
                checkOutput("wide_d1", {24'd0, w_d1}, {24'd0, 8'(base + 8'(WL % 256))});
                checkOutput("wide_d2", {24'd0, w_d2}, {24'd0, 8'(base + 8'((2 * WL) % 256))});
            end
        end
        w_valid = 1'b0;
        checkOutput("wide_pulses", pulses, WL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
